// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with SEQ/BRANCH/JUMP/CALL/RET/HALT
//               operations, a circular return-address stack, stall and
//               halt/resume control.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            STEP      = 4,
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active-low
  input  logic          en,
  input  logic [2:0]    op,
  input  logic          cond,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] target,
  input  logic          resume,
  output logic [AW-1:0] instr_addr,
  output logic          halted,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  localparam int            c_PW   = $clog2(RAS_DEPTH);
  localparam int            c_CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [AW-1:0] c_STEP = AW'(STEP);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(RAS_DEPTH);

  localparam logic [2:0] c_OP_SEQ    = 3'b000;
  localparam logic [2:0] c_OP_BRANCH = 3'b001;
  localparam logic [2:0] c_OP_JUMP   = 3'b010;
  localparam logic [2:0] c_OP_CALL   = 3'b011;
  localparam logic [2:0] c_OP_RET    = 3'b100;
  localparam logic [2:0] c_OP_HALT   = 3'b101;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_pc;
  logic [c_PW-1:0]   r_sp;      // next free slot; top of stack is r_sp-1
  logic [c_CW-1:0]   r_cnt;
  logic              r_err;
  logic [AW-1:0]     r_ras [RAS_DEPTH];

  logic              w_adv;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic [AW-1:0]     w_seq;
  logic [AW-1:0]     w_top;

  // An operation is processed only when running and enabled.
  assign w_adv   = (r_state == ST_RUN) && en;
  assign w_push  = w_adv && (op == c_OP_CALL);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_FULL);
  assign w_seq   = r_pc + c_STEP;
  assign w_top   = r_ras[r_sp - c_PW'(1)];

  // Stack storage: a push always writes the next slot; when full this slot
  // holds the oldest entry, which is therefore the one overwritten.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= w_seq;
    end
  end

  // Control FSM, program counter, stack pointer/count and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_VEC;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (resume) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          if (en) begin
            case (op)
              c_OP_BRANCH: r_pc <= cond ? (r_pc + offset) : w_seq;
              c_OP_JUMP:   r_pc <= target;
              c_OP_CALL: begin
                r_pc <= target;
                r_sp <= r_sp + c_PW'(1);
                if (w_full) begin
                  r_err <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + c_CW'(1);
                end
              end
              c_OP_RET: begin
                if (w_empty) begin
                  r_pc  <= w_seq;
                  r_err <= 1'b1;
                end else begin
                  r_pc  <= w_top;
                  r_sp  <= r_sp - c_PW'(1);
                  r_cnt <= r_cnt - c_CW'(1);
                end
              end
              c_OP_HALT:   r_state <= ST_HALT;
              default:     r_pc <= w_seq;   // SEQ and the unused encodings
            endcase
          end
        end
      endcase
    end
  end

  assign instr_addr = r_pc;
  assign halted     = (r_state == ST_HALT);
  assign ras_empty  = w_empty;
  assign ras_full   = w_full;
  assign ras_err    = r_err;

  // Retained so the unused-op encodings stay documented next to the decode.
  logic w_unused;
  assign w_unused = ^{c_OP_SEQ, w_adv};

endmodule
`default_nettype wire
